y86_fetch_unit: RTL and testbench
=================================

Y86_FETCH_UNIT -- requirements
Module: y86_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC value loaded on reset.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  byte read request.
- imem_addr  output  64  byte address; valid while imem_req=1.
- imem_ack  input  1  read data valid this cycle.
- imem_rdata  input  8  returned byte.
- imem_err  input  1  address error, qualified by imem_ack.
- pc_load  input  1  redirect request from execute/writeback.
- pc_load_val  input  64  redirect target.
- valid  output  1  decoded instruction available.
- ready  input  1  decode/register-file stage accepts.
- icode  output  4  instruction code.
- ifun  output  4  function code.
- rA  output  4  register A; 4'hF when absent.
- rB  output  4  register B; 4'hF when absent.
- valC  output  64  constant, little-endian assembled; 0 when absent.
- valP  output  64  PC plus instruction length.
- stat  output  2  0=AOK, 1=HLT, 2=ADR, 3=INS.

Function
REQ-003 SHALL implement the states FETCH_OP, FETCH_REG, FETCH_C, PRESENT and HALT.
REQ-004 SHALL hold imem_req=1 with a stable imem_addr in every FETCH_* state until imem_ack; one byte is consumed per ack cycle.
REQ-005 SHALL, on the ack in FETCH_OP, latch icode=rdata[7:4] and ifun=rdata[3:0], then go to the next state by icode:
- 0, 1, 9 -> PRESENT.
- 2, 6, 10, 11 -> FETCH_REG.
- 3, 4, 5 -> FETCH_REG, then FETCH_C.
- 7, 8 -> FETCH_C.
REQ-006 SHALL, in FETCH_REG, latch rA=rdata[7:4] and rB=rdata[3:0].
REQ-007 SHALL, in FETCH_C, use a 3-bit counter to place byte k into valC[8k+7:8k], k=0..7, and go to PRESENT after k=7.
REQ-008 SHALL set instruction lengths of 1, 2, 9 and 10 bytes as implied by REQ-005; valP SHALL equal fetch-start PC + length, modulo 2^64.
REQ-009 SHALL compute imem_addr = fetch-start PC + bytes consumed so far, modulo 2^64.
REQ-010 SHALL treat icode>11 as stat=INS with length 1 and go directly to PRESENT.
REQ-011 SHALL set stat=HLT for icode 0, and stat=AOK otherwise unless REQ-010, REQ-012 or REQ-018 applies.
REQ-012 SHALL, on imem_err with imem_ack in any byte, set stat=ADR, abandon the remaining bytes, and go to PRESENT.
REQ-013 SHALL drive valid=1 only in PRESENT, with all outputs stable until ready=1.
REQ-014 SHALL, on the valid&&ready cycle, set PC<=valP and return to FETCH_OP if stat=AOK; otherwise it SHALL go to HALT.
REQ-015 SHALL, in HALT, hold valid=0 and imem_req=0 until pc_load or rst.
REQ-016 SHALL, when pc_load=1 in any state, set PC<=pc_load_val, discard the partial or presented instruction, and go to FETCH_OP the next cycle.
REQ-017 SHALL give pc_load priority over a simultaneous valid&&ready or imem_ack.

Reset
REQ-018 SHALL, while rst=1, set state=FETCH_OP, PC=RESET_PC and valid=0, with imem_req deasserted during reset. The outputs icode, ifun and stat SHALL be 0; rA and rB SHALL be 4'hF; valC, valP and the byte counter SHALL be 0. A reset mid-fetch SHALL drop the partial instruction.

Configuration
REQ-019 SHALL implement the macro FETCH_IFUN_CHECK_EN, behaving as follows:
- Defined: stat=INS if icode 2 or 7 has ifun>6, if icode 6 has ifun>3, or if any other valid icode has ifun!=0; the instruction length is unchanged.
- Undefined: ifun is not checked.

Structure
REQ-020 SHALL take its icode constants, the stat encoding, RNONE=4'hF and the state enum from the shared package y86_pkg.
REQ-021 SHALL place the icode to length/need_regids/need_valC decode in a combinational sub-module, y86_instr_len.

Verification
REQ-022 SHALL cover the following directed scenarios on the bench:
- irmovq: bytes 30 F0 00 01 00 00 00 00 00 00 at PC 0, ack every cycle -> icode=3, rA=F, rB=0, valC=0x100, valP=10, stat=AOK.
- Backpressure and delayed ack: addq (60 01) at PC 0x20, ack delayed 3 cycles, ready held low 4 cycles -> outputs stable, valP=0x22, next imem_addr=0x22.
- halt: byte 00 -> stat=HLT, then HALT with imem_req=0; pc_load=1 with pc_load_val=0x40 -> imem_addr=0x40.
- Bad icode and address error: byte F0 -> stat=INS, valP=PC+1; imem_err on the 3rd byte of call -> stat=ADR.
- Redirect: pc_load during FETCH_C of jmp -> the partial instruction is dropped and the next request uses the new PC; rst asserted mid-fetch -> PC=RESET_PC.
- FETCH_IFUN_CHECK_EN: byte 64 -> stat=INS when the macro is defined, AOK when it is not.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode constants, status encoding and fetch states
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef enum logic [2:0] {
        FETCH_OP  = 3'd0,
        FETCH_REG = 3'd1,
        FETCH_C   = 3'd2,
        PRESENT   = 3'd3,
        HALT      = 3'd4
    } state_t;

    // Only meaningful for icodes 0..11; cmovXX and jXX have seven variants, OPq has four.
    function automatic logic ifun_bad(input logic [3:0] icode, input logic [3:0] ifun);
        case (icode)
            I_RRMOVQ, I_JXX: return ifun > 4'd6;
            I_OPQ:           return ifun > 4'd3;
            default:         return ifun != 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/y86_fetch_unit_if.sv
// rtl/y86_fetch_unit_if.sv - byte-fetch bus, redirect and decode-side handshake bundle
interface y86_fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_rdata;
    logic        imem_err;
    logic        pc_load;
    logic [63:0] pc_load_val;
    logic        valid;
    logic        ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [1:0]  stat;

    modport master (
        output imem_req, imem_addr, valid, icode, ifun, rA, rB, valC, valP, stat,
        input  imem_ack, imem_rdata, imem_err, pc_load, pc_load_val, ready
    );

    modport slave (
        input  imem_req, imem_addr, valid, icode, ifun, rA, rB, valC, valP, stat,
        output imem_ack, imem_rdata, imem_err, pc_load, pc_load_val, ready
    );
endinterface

// File: rtl/y86_instr_len.sv
// rtl/y86_instr_len.sv - icode to length / register-byte / constant-word decode
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       known,
    output logic       need_regids,
    output logic       need_valc,
    output logic [3:0] len
);

    always_comb begin
        known       = 1'b1;
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: ;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            I_JXX, I_CALL: need_valc = 1'b1;
            default: known = 1'b0;
        endcase
        len = 4'd1 + (need_regids ? 4'd1 : 4'd0) + (need_valc ? 4'd8 : 4'd0);
    end

endmodule

// File: rtl/y86_fetch_unit.sv
// rtl/y86_fetch_unit.sv - byte-serial Y86-64 instruction fetch FSM
// Optional ifun legality check: FETCH_IFUN_CHECK_EN.
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_err,
    input  logic        pc_load,
    input  logic [63:0] pc_load_val,
    output logic        valid,
    input  logic        ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [1:0]  stat
);

    state_t      state, state_nxt;
    logic [63:0] pc;
    logic [3:0]  nbytes;
    logic [2:0]  c_idx;
    logic        need_c;
    stat_t       stat_q;
    stat_t       op_stat;

    logic        op_known, op_nr, op_nc;
    logic [3:0]  op_len;
    logic        ifun_err;

    y86_instr_len u_len (
        .icode       (imem_rdata[7:4]),
        .known       (op_known),
        .need_regids (op_nr),
        .need_valc   (op_nc),
        .len         (op_len)
    );

`ifdef FETCH_IFUN_CHECK_EN
    assign ifun_err = op_known && ifun_bad(imem_rdata[7:4], imem_rdata[3:0]);
`else
    assign ifun_err = 1'b0;
`endif

    always_comb begin
        if (imem_err)                     op_stat = STAT_ADR;
        else if (!op_known || ifun_err)   op_stat = STAT_INS;
        else if (imem_rdata[7:4] == I_HALT) op_stat = STAT_HLT;
        else                              op_stat = STAT_AOK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH_OP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (pc_load) begin
            state_nxt = FETCH_OP;
        end else begin
            case (state)
                FETCH_OP: if (imem_ack) begin
                    if (imem_err || !op_known) state_nxt = PRESENT;
                    else if (op_nr)            state_nxt = FETCH_REG;
                    else if (op_nc)            state_nxt = FETCH_C;
                    else                       state_nxt = PRESENT;
                end
                FETCH_REG: if (imem_ack) state_nxt = (imem_err || !need_c) ? PRESENT : FETCH_C;
                FETCH_C:   if (imem_ack && (imem_err || c_idx == 3'd7)) state_nxt = PRESENT;
                PRESENT:   if (ready) state_nxt = (stat_q == STAT_AOK) ? FETCH_OP : HALT;
                HALT:      ;
                default:   state_nxt = FETCH_OP;
            endcase
        end
    end

    // imem_req is gated by rst so no request leaks out while the reset is held.
    always_comb begin
        imem_req = !rst && (state == FETCH_OP || state == FETCH_REG || state == FETCH_C);
        valid    = (state == PRESENT);
    end

    assign imem_addr = pc + {60'd0, nbytes};
    assign stat      = stat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            nbytes <= 4'd0;
            c_idx  <= 3'd0;
            need_c <= 1'b0;
            icode  <= 4'h0;
            ifun   <= 4'h0;
            rA     <= RNONE;
            rB     <= RNONE;
            valC   <= 64'd0;
            valP   <= 64'd0;
            stat_q <= STAT_AOK;
        end else if (pc_load) begin
            pc     <= pc_load_val;
            nbytes <= 4'd0;
            c_idx  <= 3'd0;
        end else begin
            case (state)
                FETCH_OP: if (imem_ack) begin
                    nbytes <= 4'd1;
                    c_idx  <= 3'd0;
                    icode  <= imem_rdata[7:4];
                    ifun   <= imem_rdata[3:0];
                    rA     <= RNONE;
                    rB     <= RNONE;
                    valC   <= 64'd0;
                    need_c <= op_nc;
                    valP   <= pc + {60'd0, op_len};
                    stat_q <= op_stat;
                end
                FETCH_REG: if (imem_ack) begin
                    nbytes <= nbytes + 4'd1;
                    if (imem_err) begin
                        stat_q <= STAT_ADR;
                    end else begin
                        rA <= imem_rdata[7:4];
                        rB <= imem_rdata[3:0];
                    end
                end
                FETCH_C: if (imem_ack) begin
                    nbytes <= nbytes + 4'd1;
                    c_idx  <= c_idx + 3'd1;
                    if (imem_err) stat_q <= STAT_ADR;
                    else          valC[{c_idx, 3'b000} +: 8] <= imem_rdata;
                end
                PRESENT: if (ready) begin
                    pc     <= valP;
                    nbytes <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb/tb_y86_fetch_unit.sv - directed vector bench for y86_fetch_unit
module tb_y86_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y86_fetch_unit_if bus ();

    y86_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (bus.imem_req),
        .imem_addr   (bus.imem_addr),
        .imem_ack    (bus.imem_ack),
        .imem_rdata  (bus.imem_rdata),
        .imem_err    (bus.imem_err),
        .pc_load     (bus.pc_load),
        .pc_load_val (bus.pc_load_val),
        .valid       (bus.valid),
        .ready       (bus.ready),
        .icode       (bus.icode),
        .ifun        (bus.ifun),
        .rA          (bus.rA),
        .rB          (bus.rB),
        .valC        (bus.valC),
        .valP        (bus.valP),
        .stat        (bus.stat)
    );

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        int          err_at;
        logic        full;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [1:0]  stat;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem_bytes [10];
    logic [63:0] mem_base;
    int          err_at = -1;
    int          ack_delay = 0;
    vec_t        vecs [11];

`ifdef FETCH_IFUN_CHECK_EN
    localparam logic [1:0] OPQ4_STAT = 2'd3;
`else
    localparam logic [1:0] OPQ4_STAT = 2'd0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] pc, input logic [79:0] b, input int e,
                                input logic full, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input logic [63:0] vp, input logic [1:0] st);
        vec_t v;
        v.pc = pc; v.bytes = b; v.err_at = e; v.full = full;
        v.icode = ic; v.ifun = fn; v.ra = ra; v.rb = rb;
        v.valc = vc; v.valp = vp; v.stat = st;
        return v;
    endfunction

    task automatic load_mem(input logic [63:0] base, input logic [79:0] b, input int e);
        mem_base = base;
        err_at   = e;
        for (int i = 0; i < 10; i++) mem_bytes[i] = b[79 - 8*i -: 8];
    endtask

    task automatic redirect(input logic [63:0] target);
        @(negedge clk);
        bus.pc_load = 1'b1;
        bus.pc_load_val = target;
        @(negedge clk);
        bus.pc_load = 1'b0;
    endtask

    task automatic accept();
        @(negedge clk);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    task automatic serve(input logic [7:0] b);
        @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = b;
        bus.imem_err = 1'b0;
    endtask

    // Acks requests from mem_bytes until valid rises; the address is checked on every request cycle.
    task automatic fetch_until_valid(input string tag);
        int n = 0;
        int wait_cnt = 0;
        bit ok = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            bus.imem_err = 1'b0;
            if (bus.valid) begin
                ok = 1;
                break;
            end
            if (bus.imem_req) begin
                chk({tag, ".imem_addr"}, bus.imem_addr, mem_base + 64'(n));
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = (n < 10) ? mem_bytes[n] : 8'h00;
                    bus.imem_err = (n == err_at);
                    n++;
                    wait_cnt = 0;
                end
            end
        end
        chk({tag, ".valid_timeout"}, 64'(ok), 64'd1);
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 8'h00;
        bus.imem_err = 1'b0;
        bus.pc_load = 1'b0;
        bus.pc_load_val = 64'd0;
        bus.ready = 1'b0;

        vecs[0]  = mk(64'h0,  80'h30F0_0001_0000_0000_0000, -1, 1, 4'h3, 4'h0, 4'hF, 4'h0, 64'h100, 64'd10, 2'd0);
        vecs[1]  = mk(64'h30, 80'h6123_0000_0000_0000_0000, -1, 1, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h32, 2'd0);
        vecs[2]  = mk(64'h50, 80'h1000_0000_0000_0000_0000, -1, 1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 2'd0);
        vecs[3]  = mk(64'h60, 80'h7088_7766_5544_3322_1100, -1, 1, 4'h7, 4'h0, 4'hF, 4'hF,
                      64'h1122_3344_5566_7788, 64'h69, 2'd0);
        vecs[4]  = mk(64'h80, 80'h80AA_BBCC_0000_0000_0000,  2, 0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 2'd2);
        vecs[5]  = mk(64'h90, 80'hF000_0000_0000_0000_0000, -1, 1, 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'h91, 2'd3);
        vecs[6]  = mk(64'hA0, 80'h9000_0000_0000_0000_0000, -1, 1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'hA1, 2'd0);
        vecs[7]  = mk(64'hB0, 80'h5012_0800_0000_0000_0000, -1, 1, 4'h5, 4'h0, 4'h1, 4'h2, 64'h8, 64'hBA, 2'd0);
        vecs[8]  = mk(64'hC0, 80'hA04F_0000_0000_0000_0000, -1, 1, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 64'hC2, 2'd0);
        vecs[9]  = mk(64'hD0, 80'h6400_0000_0000_0000_0000, -1, 1, 4'h6, 4'h4, 4'h0, 4'h0, 64'h0, 64'hD2, OPQ4_STAT);
        vecs[10] = mk(64'hFFFF_FFFF_FFFF_FFFF, 80'h2012_0000_0000_0000_0000, -1, 1,
                      4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h1, 2'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.imem_req", 64'(bus.imem_req), 64'd0);
        chk("rst.valid",    64'(bus.valid),    64'd0);
        chk("rst.icode",    64'(bus.icode),    64'd0);
        chk("rst.ifun",     64'(bus.ifun),     64'd0);
        chk("rst.rA",       64'(bus.rA),       64'hF);
        chk("rst.rB",       64'(bus.rB),       64'hF);
        chk("rst.valC",     bus.valC,          64'd0);
        chk("rst.valP",     bus.valP,          64'd0);
        chk("rst.stat",     64'(bus.stat),     64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.imem_req",  64'(bus.imem_req), 64'd1);
        chk("post_rst.imem_addr", bus.imem_addr,     RST_PC);

        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            redirect(vecs[i].pc);
            load_mem(vecs[i].pc, vecs[i].bytes, vecs[i].err_at);
            fetch_until_valid(tag);
            chk({tag, ".icode"}, 64'(bus.icode), 64'(vecs[i].icode));
            chk({tag, ".stat"},  64'(bus.stat),  64'(vecs[i].stat));
            if (vecs[i].full) begin
                chk({tag, ".ifun"}, 64'(bus.ifun), 64'(vecs[i].ifun));
                chk({tag, ".rA"},   64'(bus.rA),   64'(vecs[i].ra));
                chk({tag, ".rB"},   64'(bus.rB),   64'(vecs[i].rb));
                chk({tag, ".valC"}, bus.valC,      vecs[i].valc);
                chk({tag, ".valP"}, bus.valP,      vecs[i].valp);
            end
            accept();
        end

        // Backpressure with a 3-cycle ack delay and ready low for 4 cycles
        redirect(64'h20);
        load_mem(64'h20, 80'h6001_0000_0000_0000_0000, -1);
        ack_delay = 3;
        fetch_until_valid("bp");
        ack_delay = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp.valid", 64'(bus.valid), 64'd1);
            chk("bp.icode", 64'(bus.icode), 64'h6);
            chk("bp.rA",    64'(bus.rA),    64'h0);
            chk("bp.rB",    64'(bus.rB),    64'h1);
            chk("bp.valP",  bus.valP,       64'h22);
        end
        accept();
        chk("bp.next_req",  64'(bus.imem_req), 64'd1);
        chk("bp.next_addr", bus.imem_addr,     64'h22);

        // halt parks the unit until a redirect
        redirect(64'h38);
        load_mem(64'h38, 80'h0, -1);
        fetch_until_valid("halt");
        chk("halt.stat", 64'(bus.stat), 64'd1);
        chk("halt.valP", bus.valP,      64'h39);
        accept();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("halt.imem_req", 64'(bus.imem_req), 64'd0);
            chk("halt.valid",    64'(bus.valid),    64'd0);
        end
        redirect(64'h40);
        chk("halt.redir_req",  64'(bus.imem_req), 64'd1);
        chk("halt.redir_addr", bus.imem_addr,     64'h40);

        // pc_load mid-FETCH_C of jmp, coincident with an ack
        redirect(64'h100);
        serve(8'h70);
        serve(8'h11);
        serve(8'h22);
        @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 8'h33;
        bus.pc_load = 1'b1;
        bus.pc_load_val = 64'h200;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.pc_load = 1'b0;
        chk("redir.imem_req",  64'(bus.imem_req), 64'd1);
        chk("redir.imem_addr", bus.imem_addr,     64'h200);
        chk("redir.valid",     64'(bus.valid),    64'd0);
        load_mem(64'h200, 80'h1000_0000_0000_0000_0000, -1);
        fetch_until_valid("redir");
        chk("redir.icode", 64'(bus.icode), 64'h1);
        chk("redir.valP",  bus.valP,       64'h201);
        accept();

        // Reset in the middle of an irmovq
        redirect(64'h300);
        serve(8'h30);
        serve(8'hF0);
        serve(8'h00);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst.imem_req", 64'(bus.imem_req), 64'd0);
        chk("mid_rst.valid",    64'(bus.valid),    64'd0);
        chk("mid_rst.valP",     bus.valP,          64'd0);
        chk("mid_rst.rA",       64'(bus.rA),       64'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst.req",  64'(bus.imem_req), 64'd1);
        chk("mid_rst.addr", bus.imem_addr,     RST_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
